// File: rtl/fp_sqrt_pkg.sv
// Shared constants, encodings and FSM state type for the FP_sqrt datapath.
package fp_sqrt_pkg;

    localparam int unsigned M_SIZE    = 106;
    localparam int unsigned ROOT_SIZE = 53;
    localparam int unsigned DP_ITER   = 53;
    localparam int unsigned SP_ITER   = 24;
    localparam int unsigned CNT_SIZE  = 6;

    localparam logic [2:0] FLAG_DENORM   = 3'b000;
    localparam logic [2:0] FLAG_ZERO     = 3'b001;
    localparam logic [2:0] FLAG_INF      = 3'b010;
    localparam logic [2:0] FLAG_NAN      = 3'b011;
    localparam logic [2:0] FLAG_NORMAL   = 3'b100;
    localparam logic [2:0] FLAG_SIGN_ERR = 3'b111;

    localparam logic TYPE_DP = 1'b1;
    localparam logic TYPE_SP = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        BYPASS,
        DONE
    } state_t;

    // Counter preload: one less than the number of root bits to retire.
    function automatic logic [CNT_SIZE-1:0] iter_last(input logic t);
        return (t == TYPE_SP) ? CNT_SIZE'(SP_ITER - 1) : CNT_SIZE'(DP_ITER - 1);
    endfunction

endpackage

// File: rtl/sqrt_core_if.sv
// Launch/result bundle between the sqrt input wrapper, the core and the rounding stage.
interface sqrt_core_if;
    import fp_sqrt_pkg::*;

    logic                 start_sqrt;
    logic                 in_type;
    logic [2:0]           in_flags;
    logic [M_SIZE-1:0]    in_mantisa;
    logic                 busy;
    logic                 done;
    logic [ROOT_SIZE-1:0] out_root;
    logic                 sticky;
    logic [2:0]           out_flags;
    logic                 out_type;

    modport master (
        output start_sqrt, in_type, in_flags, in_mantisa,
        input  busy, done, out_root, sticky, out_flags, out_type
    );

    modport slave (
        input  start_sqrt, in_type, in_flags, in_mantisa,
        output busy, done, out_root, sticky, out_flags, out_type
    );

endinterface

// File: rtl/sqrt_core_CU.sv
// Controller for the restoring square root: launch decode, iteration counter, busy/done.
module sqrt_core_CU
    import fp_sqrt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_type,
    input  logic [2:0] i_flags,
    output logic       o_load,
    output logic       o_step,
    output logic       o_fin_calc,
    output logic       o_fin_bypass,
    output logic       o_busy,
    output logic       o_done
);

    state_t              r_state;
    logic [CNT_SIZE-1:0] r_cnt;
    logic                r_busy;
    logic                r_done;

    assign o_load       = (r_state == IDLE) && i_start;
    assign o_step       = (r_state == CALC);
    assign o_fin_calc   = (r_state == CALC) && (r_cnt == '0);
    assign o_fin_bypass = (r_state == BYPASS);
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_flags == FLAG_NORMAL) begin
                            r_state <= CALC;
                            r_cnt   <= iter_last(i_type);
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= BYPASS;
                        end
                    end
                end
                CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                BYPASS: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sqrt_core_DP.sv
// Restoring square-root datapath: radicand shifter, remainder, root, trial subtractor, result regs.
module sqrt_core_DP
    import fp_sqrt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_fin_calc,
    input  logic                 i_fin_bypass,
    input  logic                 i_type,
    input  logic [2:0]           i_flags,
    input  logic [M_SIZE-1:0]    i_mantisa,
    output logic [ROOT_SIZE-1:0] o_root,
    output logic                 o_sticky,
    output logic [2:0]           o_flags,
    output logic                 o_type
);

    logic [M_SIZE-1:0]    r_rad;
    logic [ROOT_SIZE+1:0] r_rem;
    logic [ROOT_SIZE-1:0] r_q;
    logic                 r_type;
    logic [2:0]           r_flags;

    logic [ROOT_SIZE+1:0] w_rp;
    logic [ROOT_SIZE+2:0] w_diff;
    logic                 w_ge;
    logic [ROOT_SIZE+1:0] w_rem_next;
    logic [ROOT_SIZE-1:0] w_q_next;
    logic [M_SIZE-1:0]    w_rad_next;

    // Invariant R <= 2Q keeps R' and {Q,01} inside ROOT_SIZE+2 bits, so the
    // top two remainder bits are always zero when shifted out here.
    assign w_rp       = {r_rem[ROOT_SIZE-1:0], r_rad[M_SIZE-1 -: 2]};
    assign w_diff     = {1'b0, w_rp} - {1'b0, r_q, 2'b01};
    assign w_ge       = ~w_diff[ROOT_SIZE+2];
    assign w_rem_next = w_ge ? w_diff[ROOT_SIZE+1:0] : w_rp;
    assign w_q_next   = {r_q[ROOT_SIZE-2:0], w_ge};
    assign w_rad_next = {r_rad[M_SIZE-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rad    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_type   <= 1'b0;
            r_flags  <= '0;
            o_root   <= '0;
            o_sticky <= 1'b0;
            o_flags  <= '0;
            o_type   <= 1'b0;
        end else begin
            if (i_load) begin
                r_rad   <= i_mantisa;
                r_rem   <= '0;
                r_q     <= '0;
                r_type  <= i_type;
                r_flags <= i_flags;
            end else if (i_step) begin
                r_rad <= w_rad_next;
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
            end

            // Leftover radicand bits (single precision only) fold into sticky.
            if (i_fin_calc) begin
                o_root   <= (r_type == TYPE_DP) ? w_q_next : (w_q_next << (ROOT_SIZE - SP_ITER));
                o_sticky <= (w_rem_next != '0) || (w_rad_next != '0);
                o_flags  <= r_flags;
                o_type   <= r_type;
            end else if (i_fin_bypass) begin
                o_root   <= '0;
                o_sticky <= 1'b0;
                o_flags  <= r_flags;
                o_type   <= r_type;
            end
        end
    end

endmodule

// File: rtl/sqrt_core.sv
// Iterative radix-2 restoring square-root core: one root bit per cycle, single-cycle special bypass.
module sqrt_core
    import fp_sqrt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    sqrt_core_if.slave bus
);

    logic w_load;
    logic w_step;
    logic w_fin_calc;
    logic w_fin_bypass;

    sqrt_core_CU u_cu (
        .clk          (clk),
        .rst          (rst),
        .i_start      (bus.start_sqrt),
        .i_type       (bus.in_type),
        .i_flags      (bus.in_flags),
        .o_load       (w_load),
        .o_step       (w_step),
        .o_fin_calc   (w_fin_calc),
        .o_fin_bypass (w_fin_bypass),
        .o_busy       (bus.busy),
        .o_done       (bus.done)
    );

    sqrt_core_DP u_dp (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_fin_calc   (w_fin_calc),
        .i_fin_bypass (w_fin_bypass),
        .i_type       (bus.in_type),
        .i_flags      (bus.in_flags),
        .i_mantisa    (bus.in_mantisa),
        .o_root       (bus.out_root),
        .o_sticky     (bus.sticky),
        .o_flags      (bus.out_flags),
        .o_type       (bus.out_type)
    );

endmodule

// File: tb/tb_sqrt_core.sv
// Directed-vector bench for sqrt_core: latency, roots, sticky, bypass, ignored/held start, reset abort.
module tb_sqrt_core;
    import fp_sqrt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    sqrt_core_if bus ();

    sqrt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [M_SIZE-1:0] P104 = 106'h1 << 104;
    localparam logic [M_SIZE-1:0] P105 = 106'h1 << 105;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic t, input logic [2:0] f, input logic [M_SIZE-1:0] m);
        bus.in_type    = t;
        bus.in_flags   = f;
        bus.in_mantisa = m;
        bus.start_sqrt = 1'b1;
        tick();
        bus.start_sqrt = 1'b0;
    endtask

    // lat counts the sampling-edge cycle as 1; stops on done or after a budget.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
            if (bus.busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        bus.start_sqrt = 1'b0;
        bus.in_type    = 1'b1;
        bus.in_flags   = FLAG_NORMAL;
        bus.in_mantisa = P105;
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.out_root !== '0) begin n_mis++; $display("FAIL reset_root: got %h want 0", bus.out_root); end
        n_cmp++; if (bus.sticky !== 1'b0) begin n_mis++; $display("FAIL reset_sticky: got %b want 0", bus.sticky); end
        n_cmp++; if (bus.out_flags !== 3'b000) begin n_mis++; $display("FAIL reset_flags: got %b want 000", bus.out_flags); end
        n_cmp++; if (bus.out_type !== 1'b0) begin n_mis++; $display("FAIL reset_type: got %b want 0", bus.out_type); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_dp_normal();
        logic [M_SIZE-1:0]    mant [5];
        logic [ROOT_SIZE-1:0] root [5];
        logic                 stk  [5];
        int lat, bc;
        mant[0] = P104;                      root[0] = 53'h10000000000000; stk[0] = 1'b0;
        mant[1] = P105;                      root[1] = 53'h16A09E667F3BCC; stk[1] = 1'b1;
        mant[2] = 106'd9 << 102;             root[2] = 53'h18000000000000; stk[2] = 1'b0;
        mant[3] = '1;                        root[3] = 53'h1FFFFFFFFFFFFF; stk[3] = 1'b1;
        mant[4] = P104 | 106'd1;             root[4] = 53'h10000000000000; stk[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            launch(TYPE_DP, FLAG_NORMAL, mant[i]);
            wait_done(lat, bc);
            n_cmp++; if (lat != 54) begin n_mis++; $display("FAIL dp_latency[%0d]: got %0d want 54", i, lat); end
            n_cmp++; if (bc != 53) begin n_mis++; $display("FAIL dp_busy_cycles[%0d]: got %0d want 53", i, bc); end
            n_cmp++; if (bus.out_root !== root[i]) begin n_mis++; $display("FAIL dp_root[%0d]: got %h want %h", i, bus.out_root, root[i]); end
            n_cmp++; if (bus.sticky !== stk[i]) begin n_mis++; $display("FAIL dp_sticky[%0d]: got %b want %b", i, bus.sticky, stk[i]); end
            n_cmp++; if (bus.out_flags !== FLAG_NORMAL || bus.out_type !== TYPE_DP) begin
                n_mis++; $display("FAIL dp_flags_type[%0d]: got %b/%b want 100/1", i, bus.out_flags, bus.out_type); end
            tick();
            n_cmp++; if (bus.done !== 1'b0) begin n_mis++; $display("FAIL dp_done_pulse[%0d]: got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_sp_normal();
        logic [M_SIZE-1:0]    mant [3];
        logic [ROOT_SIZE-1:0] root [3];
        logic                 stk  [3];
        int lat, bc;
        mant[0] = P104;                      root[0] = 53'h10000000000000; stk[0] = 1'b0;
        mant[1] = P104 | (106'h1 << 57);     root[1] = 53'h10000000000000; stk[1] = 1'b1;
        mant[2] = {48'hFFFFFFFFFFFF, 58'h0}; root[2] = 53'h1FFFFFE0000000; stk[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            launch(TYPE_SP, FLAG_NORMAL, mant[i]);
            wait_done(lat, bc);
            n_cmp++; if (lat != 25) begin n_mis++; $display("FAIL sp_latency[%0d]: got %0d want 25", i, lat); end
            n_cmp++; if (bc != 24) begin n_mis++; $display("FAIL sp_busy_cycles[%0d]: got %0d want 24", i, bc); end
            n_cmp++; if (bus.out_root !== root[i]) begin n_mis++; $display("FAIL sp_root[%0d]: got %h want %h", i, bus.out_root, root[i]); end
            n_cmp++; if (bus.sticky !== stk[i]) begin n_mis++; $display("FAIL sp_sticky[%0d]: got %b want %b", i, bus.sticky, stk[i]); end
            n_cmp++; if (bus.out_type !== TYPE_SP) begin n_mis++; $display("FAIL sp_type[%0d]: got %b want 0", i, bus.out_type); end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [2:0] fl [5];
        int lat, bc;
        logic t;
        fl[0] = FLAG_ZERO; fl[1] = FLAG_SIGN_ERR; fl[2] = FLAG_INF; fl[3] = FLAG_NAN; fl[4] = FLAG_DENORM;
        for (int i = 0; i < 5; i++) begin
            t = i[0];
            launch(t, fl[i], P105);
            wait_done(lat, bc);
            n_cmp++; if (lat != 2) begin n_mis++; $display("FAIL byp_latency[%0d]: got %0d want 2", i, lat); end
            n_cmp++; if (bc != 0) begin n_mis++; $display("FAIL byp_busy[%0d]: got %0d want 0", i, bc); end
            n_cmp++; if (bus.out_root !== '0 || bus.sticky !== 1'b0) begin
                n_mis++; $display("FAIL byp_result[%0d]: got %h/%b want 0/0", i, bus.out_root, bus.sticky); end
            n_cmp++; if (bus.out_flags !== fl[i] || bus.out_type !== t) begin
                n_mis++; $display("FAIL byp_flags_type[%0d]: got %b/%b want %b/%b", i, bus.out_flags, bus.out_type, fl[i], t); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int cyc = 1;
        int first = 0;
        int pulses = 0;
        launch(TYPE_DP, FLAG_NORMAL, P105);
        repeat (90) begin
            if (cyc == 9) begin
                bus.start_sqrt = 1'b1;
                bus.in_mantisa = P104;
                bus.in_flags   = FLAG_ZERO;
                bus.in_type    = TYPE_SP;
            end else if (cyc == 10) begin
                bus.start_sqrt = 1'b0;
            end
            tick();
            cyc++;
            if (bus.done === 1'b1) begin
                pulses++;
                if (first == 0) first = cyc;
            end
        end
        n_cmp++; if (pulses != 1) begin n_mis++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
        n_cmp++; if (first != 54) begin n_mis++; $display("FAIL ign_latency: got %0d want 54", first); end
        n_cmp++; if (bus.out_root !== 53'h16A09E667F3BCC || bus.sticky !== 1'b1) begin
            n_mis++; $display("FAIL ign_result: got %h/%b want 16a09e667f3bcc/1", bus.out_root, bus.sticky); end
        n_cmp++; if (bus.out_flags !== FLAG_NORMAL || bus.out_type !== TYPE_DP) begin
            n_mis++; $display("FAIL ign_flags_type: got %b/%b want 100/1", bus.out_flags, bus.out_type); end
    endtask

    task automatic test_held_start();
        int cyc = 1;
        int pulses = 0;
        int second = 0;
        bus.in_type    = TYPE_DP;
        bus.in_flags   = FLAG_ZERO;
        bus.in_mantisa = P104;
        bus.start_sqrt = 1'b1;
        tick();
        while (cyc < 12) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) begin
                pulses++;
                if (pulses == 2) second = cyc;
            end
        end
        bus.start_sqrt = 1'b0;
        repeat (4) tick();
        n_cmp++; if (pulses != 4) begin n_mis++; $display("FAIL held_pulses: got %0d want 4", pulses); end
        n_cmp++; if (second != 5) begin n_mis++; $display("FAIL held_relaunch: got %0d want 5", second); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int pulses = 0;
        launch(TYPE_DP, FLAG_NORMAL, P104);
        wait_done(lat, bc);
        tick();
        launch(TYPE_DP, FLAG_NORMAL, P105);
        repeat (18) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_mis++; $display("FAIL rmid_busy_done: got %b/%b want 0/0", bus.busy, bus.done); end
        n_cmp++; if (bus.out_root !== '0 || bus.sticky !== 1'b0) begin
            n_mis++; $display("FAIL rmid_result: got %h/%b want 0/0", bus.out_root, bus.sticky); end
        n_cmp++; if (bus.out_flags !== 3'b000 || bus.out_type !== 1'b0) begin
            n_mis++; $display("FAIL rmid_flags_type: got %b/%b want 000/0", bus.out_flags, bus.out_type); end
        repeat (80) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_mis++; $display("FAIL rmid_no_done: got %0d active cycles want 0", pulses); end
        launch(TYPE_SP, FLAG_NORMAL, P104);
        wait_done(lat, bc);
        n_cmp++; if (lat != 25) begin n_mis++; $display("FAIL rmid_fresh_latency: got %0d want 25", lat); end
        n_cmp++; if (bus.out_root !== 53'h10000000000000 || bus.sticky !== 1'b0) begin
            n_mis++; $display("FAIL rmid_fresh_result: got %h/%b want 10000000000000/0", bus.out_root, bus.sticky); end
        tick();
    endtask

    initial begin
        test_reset();
        test_dp_normal();
        test_sp_normal();
        test_bypass();
        test_ignore_start();
        test_held_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
